// File: rtl/regbank_pkg.sv
// Shared types and the word next-value rule for the regbank storage array.
package regbank_pkg;

    localparam int MAXW = 64;

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        CLEAR = 2'd1,
        INC   = 2'd2,
        DEC   = 2'd3
    } wr_op_e;

    // Operates on a MAXW-wide container; callers truncate back to their own WIDTH,
    // the mask keeps the wrap-around explicit for widths below MAXW.
    function automatic logic [MAXW-1:0] next_word(
        input wr_op_e          op,
        input logic [MAXW-1:0] cur,
        input logic [MAXW-1:0] data,
        input int              width
    );
        logic [MAXW-1:0] r;
        logic [MAXW-1:0] mask;
        mask = (width >= MAXW) ? '1 : ((MAXW'(1) << width) - MAXW'(1));
        case (op)
            LOAD:    r = data;
            CLEAR:   r = '0;
            INC:     r = cur + MAXW'(1);
            default: r = cur - MAXW'(1);
        endcase
        return r & mask;
    endfunction

endpackage

// File: rtl/regbank_cell.sv
// One storage word of the bank: async-reset register applying a write command when enabled.
module regbank_cell
    import regbank_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  wr_op_e           op,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic             zero
);

    logic [WIDTH-1:0] nxt;

    assign nxt  = WIDTH'(next_word(op, MAXW'(q), MAXW'(d), WIDTH));
    assign zero = (q == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (en) begin
            q <= nxt;
        end
    end

endmodule

// File: rtl/regbank.sv
// DEPTH x WIDTH register bank: one load/clear/inc/dec write port, two combinational
// read ports with optional write-to-read bypass, per-word zero flags.
module regbank
    import regbank_pkg::*;
#(
    parameter int  WIDTH  = 16,
    parameter int  DEPTH  = 8,
    parameter int  BYPASS = 1,
    localparam int AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [1:0]       wr_op,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [AW-1:0]    rd_addr_a,
    output logic [WIDTH-1:0] rd_data_a,
    input  logic [AW-1:0]    rd_addr_b,
    output logic [WIDTH-1:0] rd_data_b,
    output logic             wr_err,
    output logic [DEPTH-1:0] zero_flags
);

    logic [WIDTH-1:0] q [DEPTH];
    logic [DEPTH-1:0] cell_en;
    logic [WIDTH-1:0] wr_cur;
    logic [WIDTH-1:0] wr_next;
    logic [WIDTH-1:0] stored_a;
    logic [WIDTH-1:0] stored_b;
    logic             wr_hit;
    logic             byp_a;
    logic             byp_b;
    wr_op_e           op_e;

    assign op_e = wr_op_e'(wr_op);

    // Address compare against every word index: an out-of-range address matches
    // nothing, so it enables no cell and reads back as 0 without extra checks.
    always_comb begin
        cell_en  = '0;
        wr_cur   = '0;
        stored_a = '0;
        stored_b = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (wr_addr == AW'(i)) begin
                cell_en[i] = wr_en;
                wr_cur     = q[i];
            end
            if (rd_addr_a == AW'(i)) stored_a = q[i];
            if (rd_addr_b == AW'(i)) stored_b = q[i];
        end
    end

    assign wr_hit  = |cell_en;
    assign wr_next = WIDTH'(next_word(op_e, MAXW'(wr_cur), MAXW'(wr_data), WIDTH));

    // Bypass is suppressed while in reset so reads show the cleared array.
    assign byp_a = (BYPASS != 0) && rst_n && wr_hit && (rd_addr_a == wr_addr);
    assign byp_b = (BYPASS != 0) && rst_n && wr_hit && (rd_addr_b == wr_addr);

    assign rd_data_a = byp_a ? wr_next : stored_a;
    assign rd_data_b = byp_b ? wr_next : stored_b;

    for (genvar g = 0; g < DEPTH; g++) begin : g_cell
        regbank_cell #(.WIDTH(WIDTH)) u_cell (
            .clk   (clk),
            .rst_n (rst_n),
            .en    (cell_en[g]),
            .op    (op_e),
            .d     (wr_data),
            .q     (q[g]),
            .zero  (zero_flags[g])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_err <= 1'b0;
        end else begin
            wr_err <= wr_en && !wr_hit;
        end
    end

endmodule

// File: tb/tb_regbank.sv
// Directed bench for regbank: three instances (bypass/depth 8, no-bypass/depth 8,
// bypass/depth 6) share one set of inputs; expectations are hand-computed.
module tb_regbank;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wr_en;
    logic [1:0]  wr_op;
    logic [2:0]  wr_addr;
    logic [15:0] wr_data;
    logic [2:0]  rd_addr_a;
    logic [2:0]  rd_addr_b;

    logic [15:0] a0, b0, a1, b1, a2, b2;
    logic        err0, err1, err2;
    logic [7:0]  zf0, zf1;
    logic [5:0]  zf2;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    regbank #(.WIDTH(16), .DEPTH(8), .BYPASS(1)) dut0 (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_op(wr_op), .wr_addr(wr_addr),
        .wr_data(wr_data), .rd_addr_a(rd_addr_a), .rd_data_a(a0),
        .rd_addr_b(rd_addr_b), .rd_data_b(b0), .wr_err(err0), .zero_flags(zf0));

    regbank #(.WIDTH(16), .DEPTH(8), .BYPASS(0)) dut1 (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_op(wr_op), .wr_addr(wr_addr),
        .wr_data(wr_data), .rd_addr_a(rd_addr_a), .rd_data_a(a1),
        .rd_addr_b(rd_addr_b), .rd_data_b(b1), .wr_err(err1), .zero_flags(zf1));

    regbank #(.WIDTH(16), .DEPTH(6), .BYPASS(1)) dut2 (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_op(wr_op), .wr_addr(wr_addr),
        .wr_data(wr_data), .rd_addr_a(rd_addr_a), .rd_data_a(a2),
        .rd_addr_b(rd_addr_b), .rd_data_b(b2), .wr_err(err2), .zero_flags(zf2));

    typedef struct {
        logic        en;
        logic [1:0]  op;
        logic [2:0]  addr;
        logic [15:0] data;
        logic [2:0]  ra;
        logic [2:0]  rb;
        logic [15:0] ea;
        logic [15:0] eb;
        logic [7:0]  ezf;
        logic        eerr2;
    } vec_t;

    vec_t vecs [10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic en, input logic [1:0] op, input logic [2:0] addr,
                         input logic [15:0] data, input logic [2:0] ra, input logic [2:0] rb);
        wr_en = en; wr_op = op; wr_addr = addr; wr_data = data;
        rd_addr_a = ra; rd_addr_b = rb;
    endtask

    initial begin
        // op codes: 0 LOAD, 1 CLEAR, 2 INC, 3 DEC
        vecs[0] = '{1'b1, 2'd0, 3'd3, 16'hBEEF, 3'd3, 3'd3, 16'hBEEF, 16'hBEEF, 8'hF7, 1'b0};
        vecs[1] = '{1'b1, 2'd0, 3'd1, 16'hFFFF, 3'd1, 3'd3, 16'hFFFF, 16'hBEEF, 8'hF5, 1'b0};
        vecs[2] = '{1'b1, 2'd2, 3'd1, 16'h0000, 3'd1, 3'd1, 16'h0000, 16'h0000, 8'hF7, 1'b0};
        vecs[3] = '{1'b1, 2'd3, 3'd1, 16'h1234, 3'd1, 3'd0, 16'hFFFF, 16'h0000, 8'hF5, 1'b0};
        vecs[4] = '{1'b1, 2'd0, 3'd2, 16'h0005, 3'd2, 3'd3, 16'h0005, 16'hBEEF, 8'hF1, 1'b0};
        vecs[5] = '{1'b1, 2'd1, 3'd3, 16'hAAAA, 3'd3, 3'd2, 16'h0000, 16'h0005, 8'hF9, 1'b0};
        vecs[6] = '{1'b1, 2'd3, 3'd0, 16'h0000, 3'd0, 3'd0, 16'hFFFF, 16'hFFFF, 8'hF8, 1'b0};
        vecs[7] = '{1'b1, 2'd2, 3'd0, 16'h0000, 3'd0, 3'd7, 16'h0000, 16'h0000, 8'hF9, 1'b0};
        vecs[8] = '{1'b1, 2'd0, 3'd7, 16'h00A5, 3'd7, 3'd6, 16'h00A5, 16'h0000, 8'h79, 1'b1};
        vecs[9] = '{1'b0, 2'd0, 3'd6, 16'h1234, 3'd6, 3'd7, 16'h0000, 16'h00A5, 8'h79, 1'b0};

        rst_n = 1'b0;
        drive(1'b0, 2'd0, 3'd0, 16'h0, 3'd0, 3'd0);
        repeat (2) @(posedge clk);
        #1;
        chk("reset_zf0", 32'(zf0), 32'hFF);
        chk("reset_zf2", 32'(zf2), 32'h3F);
        chk("reset_err0", 32'(err0), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            rd_addr_a = 3'(i);
            rd_addr_b = 3'(7 - i);
            #1;
            chk("reset_rda", 32'(a0), 32'h0);
            chk("reset_rdb", 32'(b0), 32'h0);
        end

        // Table: command committed on one edge, stored values read back with wr_en low.
        for (int i = 0; i < 10; i++) begin
            drive(vecs[i].en, vecs[i].op, vecs[i].addr, vecs[i].data, vecs[i].ra, vecs[i].rb);
            @(posedge clk);
            #1;
            wr_en = 1'b0;
            #1;
            chk($sformatf("vec%0d_rda", i), 32'(a0), 32'(vecs[i].ea));
            chk($sformatf("vec%0d_rdb", i), 32'(b0), 32'(vecs[i].eb));
            chk($sformatf("vec%0d_zf", i), 32'(zf0), 32'(vecs[i].ezf));
            chk($sformatf("vec%0d_err0", i), 32'(err0), 32'h0);
            chk($sformatf("vec%0d_err2", i), 32'(err2), 32'(vecs[i].eerr2));
        end

        // Bypass: INC word 2 (=5); bypassing instance shows 6 the same cycle.
        drive(1'b1, 2'd2, 3'd2, 16'h0, 3'd2, 3'd3);
        #1;
        chk("byp_inc_a0", 32'(a0), 32'h6);
        chk("nobyp_inc_a1", 32'(a1), 32'h5);
        chk("byp_other_b0", 32'(b0), 32'h0);
        chk("byp_zf_not_bypassed", 32'(zf0[2]), 32'h0);
        @(posedge clk);
        #1;
        wr_en = 1'b0;
        #1;
        chk("nobyp_next_a1", 32'(a1), 32'h6);
        chk("byp_next_a0", 32'(a0), 32'h6);

        // Back-to-back INC on word 2, both ports on the written word.
        drive(1'b1, 2'd2, 3'd2, 16'h0, 3'd2, 3'd2);
        #1;
        chk("b2b_byp_a0", 32'(a0), 32'h7);
        chk("b2b_byp_b0", 32'(b0), 32'h7);
        @(posedge clk);
        #1;
        chk("b2b_byp2_a0", 32'(a0), 32'h8);
        chk("b2b_stored_a1", 32'(a1), 32'h7);
        @(posedge clk);
        #1;
        wr_en = 1'b0;
        #1;
        chk("b2b_final_a0", 32'(a0), 32'h8);
        chk("b2b_final_b1", 32'(b1), 32'h8);

        // Out-of-range write/read on the depth-6 instance.
        drive(1'b1, 2'd0, 3'd7, 16'h1111, 3'd7, 3'd6);
        #1;
        chk("oor_rd_a2", 32'(a2), 32'h0);
        chk("oor_rd_b2", 32'(b2), 32'h0);
        chk("oor_err2_pre", 32'(err2), 32'h0);
        @(posedge clk);
        #1;
        wr_en = 1'b0;
        #1;
        chk("oor_err2", 32'(err2), 32'h1);
        chk("oor_err0", 32'(err0), 32'h0);
        chk("oor_inrange_a0", 32'(a0), 32'h1111);
        chk("oor_zf2", 32'(zf2), 32'h39);
        chk("oor_rd_after_a2", 32'(a2), 32'h0);
        @(posedge clk);
        #1;
        chk("oor_err2_one_cycle", 32'(err2), 32'h0);

        // Asynchronous reset mid-cycle with commands in flight.
        drive(1'b1, 2'd0, 3'd0, 16'h1234, 3'd0, 3'd4);
        @(posedge clk);
        #1;
        drive(1'b1, 2'd0, 3'd6, 16'h0066, 3'd0, 3'd6);
        #1;
        chk("rst_pre_a0", 32'(a0), 32'h1234);
        @(posedge clk);
        #1;
        chk("rst_pre_err2", 32'(err2), 32'h1);
        drive(1'b1, 2'd0, 3'd4, 16'h4444, 3'd0, 3'd4);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_a0", 32'(a0), 32'h0);
        chk("rst_mid_b0", 32'(b0), 32'h0);
        chk("rst_mid_zf0", 32'(zf0), 32'hFF);
        chk("rst_mid_err2", 32'(err2), 32'h0);
        #3;
        rst_n = 1'b1;
        #1;
        chk("rst_rel_b1", 32'(b1), 32'h0);
        chk("rst_rel_zf1", 32'(zf1), 32'hFF);
        @(posedge clk);
        #1;
        wr_en = 1'b0;
        #1;
        chk("rst_first_write_b1", 32'(b1), 32'h4444);
        chk("rst_first_write_zf1", 32'(zf1), 32'hEF);
        chk("rst_first_write_a1", 32'(a1), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/regbank.md
# regbank

Parametrised multi-word register bank that generalises the team's fixed 16-bit enable latch into an edge-triggered, resettable storage array. It holds DEPTH words of WIDTH bits each. Each cycle it accepts one write command (load, clear, increment or decrement) and serves two independent read ports, with optional write-to-read bypass. It is the storage element beneath the datapath's register file and counter banks.

## Interface
- WIDTH, 16, bits per word (≥1)
- DEPTH, 8, number of words (≥2; need not be a power of two)
- BYPASS, 1, 1 = read ports return the value being written this cycle; 0 = read ports return stored value only
- AW, $clog2(DEPTH), address width (derived, not overridable)
- clk  input  1  rising-edge clock; the only clock
- rst_n  input  1  asynchronous, active-low reset
- wr_en  input  1  write command valid this cycle
- wr_op  input  2  command: LOAD=0, CLEAR=1, INC=2, DEC=3
- wr_addr  input  AW  target word
- wr_data  input  WIDTH  operand for LOAD; ignored for other ops
- rd_addr_a  input  AW  read port A address
- rd_data_a  output  WIDTH  read port A data
- rd_addr_b  input  AW  read port B address
- rd_data_b  output  WIDTH  read port B data
- wr_err  output  1  registered; 1 for one cycle after a write to an out-of-range address
- zero_flags  output  DEPTH  bit i = 1 when stored word i == 0

## Operation
- Next-value rule for the addressed word:
  - LOAD: wr_data
  - CLEAR: 0
  - INC: word+1, modulo 2^WIDTH (all-ones wraps to 0)
  - DEC: word−1, modulo 2^WIDTH (0 wraps to all-ones)
- Non-addressed words hold their value.
- wr_en=0: no word changes, whatever the other write inputs are.
- Out-of-range address (≥DEPTH):
  - Write: no storage change; wr_err=1 on the next cycle.
  - Read: that port returns 0.
- Reads are combinational from the stored array (zero-cycle latency).
- Bypass (BYPASS=1) applies when wr_en=1, wr_addr is in range and rd_addr_x==wr_addr. In that case rd_data_x shows the computed next value, so INC on 5 reads 6 in the same cycle. Both ports bypass independently.
- Both read ports may address the same word; both return the same value.
- zero_flags are derived from stored values only and are never bypassed.

## Timing
- Writes commit on the rising clk edge; the new value is visible on the stored path from the following cycle.
- Single-cycle read-modify-write for INC/DEC; no stall and no back-pressure. A command is accepted every cycle.
- Back-to-back INC to the same word in consecutive cycles increments twice; no hazard.
- Reset values, applied asynchronously the moment rst_n falls, regardless of clk:
  - every word = 0
  - zero_flags = all ones
  - wr_err = 0
  - rd_data_a / rd_data_b reflect the zeroed array (0 for any address)
- Reset takes effect mid-command: the in-flight write is discarded.
- First write after release: the first rising edge with rst_n=1.

## Structure
- Package regbank_pkg:
  - wr_op enum (LOAD, CLEAR, INC, DEC)
  - next-value function of (op, current, data, WIDTH)
- Sub-module regbank_cell:
  - one WIDTH-bit register with async active-low reset, enable, op and data inputs
  - instantiated DEPTH times via generate
  - outputs q and a zero flag
- Top level holds:
  - write-address decode with range check
  - two read muxes with bypass
  - the wr_err flop

## Test plan
- Reset then read all addresses -> every rd_data = 0, zero_flags = all ones, wr_err = 0.
- LOAD 0xBEEF to addr 3, next cycle read A=3, B=3 -> both 0xBEEF; zero_flags[3] = 0.
- LOAD 0xFFFF to addr 1, then INC addr 1 -> reads 0x0000, zero_flags[1] = 1; then DEC addr 1 -> 0xFFFF.
- BYPASS=1, word 2 = 5, INC addr 2 with rd_addr_a = 2 -> rd_data_a = 6 the same cycle. Repeat with BYPASS=0 -> rd_data_a = 5, then 6 next cycle.
- DEPTH=6, write addr 7 -> no word changes, wr_err = 1 for exactly one cycle; read addr 7 -> 0.
- LOAD 0x1234 to addr 0, assert rst_n=0 between clock edges -> rd_data immediately 0; a command held across reset release is not applied before the first post-release edge.
